// File: rtl/spi_slave.sv
// SPI responder: synchronizes sclk/cs_n/mosi into the clk domain, receives
// frames into a show-ahead RX FIFO and shifts out a single-word TX holding
// register on miso.
module spi_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [5:0]            frame_bits,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_read,
  output logic                  rx_full,
  output logic [AW:0]           rx_count,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  input  logic                  ov_clear,
  input  logic                  ur_clear,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  // Synchronizer chains; the third sclk/cs_n flop is the edge-detect reference.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sampled_q, sampled_d;
  logic [DATA_WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-2:0] tx_shift_q, tx_shift_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ov_q, ov_d;
  logic                  ur_q, ur_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;

  logic                  sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic                  cs_fall, cs_rise;
  logic [CW-1:0]         eff_n;
  logic [DATA_WIDTH-1:0] rx_next, aligned;
  logic                  load, push, ur_set;
  logic                  pop, full, push_ok, ov_set;

  assign sclk_rise   = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall   = ~sclk_s2_q & sclk_s3_q;
  assign sample_edge = (cpol == cpha) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol == cpha) ? sclk_fall : sclk_rise;
  assign cs_fall     = ~cs_s2_q & cs_s3_q;
  assign cs_rise     = cs_s2_q & ~cs_s3_q;

  // Out-of-range frame widths fall back to the full word width.
  assign eff_n = ((frame_bits == 6'd0) || (32'(frame_bits) > DATA_WIDTH))
                 ? CW'(DATA_WIDTH) : CW'(frame_bits);

  // Holding word moved so its bit N-1 sits at the top of the shifter.
  assign aligned = hold_q << (CW'(DATA_WIDTH) - eff_n);
  assign rx_next = {rx_shift_q, mosi_s2_q};

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = fifo_mem[rd_ptr_q];
  assign rx_valid    = (count_q != '0);
  assign rx_full     = full;
  assign rx_count    = count_q;
  assign rx_overflow = ov_q;
  assign tx_underrun = ur_q;
  assign busy        = (state_q == SHIFT);

  // Next-state, shifter, holding-register and frame-load logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sampled_d   = sampled_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    push        = 1'b0;
    ur_set      = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (enable && cs_fall) load = 1'b1;
      end
      SHIFT: begin
        if (!enable || cs_rise) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = rx_next[DATA_WIDTH-2:0];
          bit_cnt_d  = bit_cnt_q - CW'(1);
          sampled_d  = 1'b1;
          if (bit_cnt_q == CW'(1)) begin
            push = 1'b1;
            load = 1'b1;
          end
        end else if (shift_edge && sampled_q) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-3:0], 1'b0};
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = SHIFT;
      bit_cnt_d  = eff_n;
      sampled_d  = 1'b0;
      rx_shift_d = '0;
      miso_oe_d  = 1'b1;
      if (hold_full_q) begin
        tx_shift_d  = aligned[DATA_WIDTH-2:0];
        miso_d      = aligned[DATA_WIDTH-1];
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        miso_d     = 1'b0;
        ur_set     = 1'b1;
      end
    end
  end

  // FIFO pointer/count update and sticky-flag logic (set beats clear).
  always_comb begin
    pop      = rx_read && (count_q != '0);
    full     = (count_q == DEPTH_C);
    push_ok  = push && (!full || pop);
    ov_set   = push && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push_ok) count_d = count_q - (AW+1)'(1);
    ov_d = ov_set ? 1'b1 : (ov_clear ? 1'b0 : ov_q);
    ur_d = ur_set ? 1'b1 : (ur_clear ? 1'b0 : ur_q);
  end

  // State, synchronizers and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sclk_s1_q   <= cpol;
      sclk_s2_q   <= cpol;
      sclk_s3_q   <= cpol;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      bit_cnt_q   <= '0;
      sampled_q   <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ov_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      cs_s1_q     <= cs_n;
      cs_s2_q     <= cs_s1_q;
      cs_s3_q     <= cs_s2_q;
      mosi_s1_q   <= mosi;
      mosi_s2_q   <= mosi_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      sampled_q   <= sampled_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ov_q        <= ov_d;
      ur_q        <= ur_d;
    end
  end

  // FIFO storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_next;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI master model and checks
// miso words, RX FIFO contents, flags and reset behaviour.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 80;  // half sclk period = 8 clk

  logic        clk = 1'b0;
  logic        reset, enable, cpol, cpha;
  logic [5:0]  frame_bits;
  logic        sclk, cs_n, mosi;
  logic        miso, miso_oe;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_read, rx_full;
  logic [4:0]  rx_count;
  logic        rx_overflow, tx_underrun, ov_clear, ur_clear, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] got;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cpol(cpol), .cpha(cpha),
    .frame_bits(frame_bits), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_read(rx_read), .rx_full(rx_full), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .ov_clear(ov_clear), .ur_clear(ur_clear), .busy(busy)
  );

  task automatic tx_write(input logic [31:0] v);
    @(negedge clk);
    tx_data = v; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_read();
    rx_read = 1'b1; @(negedge clk); rx_read = 1'b0;
  endtask

  task automatic pulse_ur_clear();
    ur_clear = 1'b1; @(negedge clk); ur_clear = 1'b0;
  endtask

  task automatic pulse_ov_clear();
    ov_clear = 1'b1; @(negedge clk); ov_clear = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    #HALF; cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic [5:0] nb);
    cpol = pol; cpha = pha; frame_bits = nb; sclk = pol;
    repeat (4) @(negedge clk);
  endtask

  // Master model: MSB first, miso captured at each sample edge.
  task automatic spi_frame(input logic [31:0] mo, input int n, output logic [31:0] mi);
    mi = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        #HALF;
        mi = {mi[30:0], miso};
        sclk = ~sclk;
        #HALF;
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = mo[i];
        #HALF;
        mi = {mi[30:0], miso};
        sclk = ~sclk;
        #HALF;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got oe=%b miso=%b want 0/0", miso_oe, miso); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    vectors++; if (rx_valid !== 1'b0 || rx_count !== 5'd0 || rx_full !== 1'b0) begin miscompares++; $display("FAIL reset_fifo: got v=%b c=%0d f=%b want 0/0/0", rx_valid, rx_count, rx_full); end
    vectors++; if (rx_overflow !== 1'b0 || tx_underrun !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got ov=%b ur=%b want 0/0", rx_overflow, tx_underrun); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mode0();
    set_mode(1'b0, 1'b0, 6'd8);
    tx_write(32'hA5);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL m0_tx_ready_full: got %b want 0", tx_ready); end
    cs_low();
    vectors++; if (busy !== 1'b1 || miso_oe !== 1'b1 || miso !== 1'b1) begin miscompares++; $display("FAIL m0_load: got busy=%b oe=%b miso=%b want 1/1/1", busy, miso_oe, miso); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL m0_consume: got %b want 1", tx_ready); end
    spi_frame(32'h3C, 8, got);
    vectors++; if (got !== 32'hA5) begin miscompares++; $display("FAIL m0_miso: got %h want 000000a5", got); end
    cs_high();
    vectors++; if (rx_data !== 32'h0000003C) begin miscompares++; $display("FAIL m0_rx_data: got %h want 0000003c", rx_data); end
    vectors++; if (rx_count !== 5'd1 || rx_valid !== 1'b1) begin miscompares++; $display("FAIL m0_rx_count: got %0d v=%b want 1/1", rx_count, rx_valid); end
    vectors++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin miscompares++; $display("FAIL m0_idle: got busy=%b oe=%b want 0/0", busy, miso_oe); end
    // completion reload found the holding register empty
    vectors++; if (tx_underrun !== 1'b1) begin miscompares++; $display("FAIL m0_tail_underrun: got %b want 1", tx_underrun); end
    pulse_ur_clear();
    pulse_read();
    vectors++; if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin miscompares++; $display("FAIL m0_pop: got v=%b c=%0d want 0/0", rx_valid, rx_count); end
  endtask

  task automatic test_mode3();
    set_mode(1'b1, 1'b1, 6'd0);  // 0 selects the full 32-bit width
    tx_write(32'hDEADBEEF);
    cs_low();
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL m3_consume: got %b want 1", tx_ready); end
    tx_write(32'h13579BDF);  // keeps the completion reload fed
    spi_frame(32'h12345678, 32, got);
    vectors++; if (got !== 32'hDEADBEEF) begin miscompares++; $display("FAIL m3_miso: got %h want deadbeef", got); end
    cs_high();
    vectors++; if (rx_data !== 32'h12345678 || rx_count !== 5'd1) begin miscompares++; $display("FAIL m3_rx: got %h c=%0d want 12345678/1", rx_data, rx_count); end
    vectors++; if (tx_underrun !== 1'b0) begin miscompares++; $display("FAIL m3_underrun: got %b want 0", tx_underrun); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL m3_tx_ready: got %b want 1", tx_ready); end
    pulse_read();
  endtask

  task automatic test_back_to_back();
    set_mode(1'b0, 1'b0, 6'd16);
    tx_write(32'hC3A5);
    cs_low();
    spi_frame(32'hBEEF, 16, got);
    vectors++; if (got !== 32'h0000C3A5) begin miscompares++; $display("FAIL b2b_miso0: got %h want 0000c3a5", got); end
    spi_frame(32'h1234, 16, got);
    vectors++; if (got !== 32'h00000000) begin miscompares++; $display("FAIL b2b_miso1: got %h want 00000000", got); end
    cs_high();
    vectors++; if (tx_underrun !== 1'b1) begin miscompares++; $display("FAIL b2b_underrun: got %b want 1", tx_underrun); end
    vectors++; if (rx_count !== 5'd2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", rx_count); end
    vectors++; if (rx_data !== 32'h0000BEEF) begin miscompares++; $display("FAIL b2b_rx0: got %h want 0000beef", rx_data); end
    pulse_read();
    vectors++; if (rx_data !== 32'h00001234) begin miscompares++; $display("FAIL b2b_rx1: got %h want 00001234", rx_data); end
    pulse_read();
    pulse_ur_clear();
    vectors++; if (tx_underrun !== 1'b0) begin miscompares++; $display("FAIL b2b_ur_clear: got %b want 0", tx_underrun); end
  endtask

  task automatic test_overflow();
    set_mode(1'b0, 1'b0, 6'd8);
    cs_low();
    for (int k = 0; k < 17; k++) spi_frame(32'h10 + k, 8, got);
    cs_high();
    vectors++; if (rx_count !== 5'd16 || rx_full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got c=%0d f=%b want 16/1", rx_count, rx_full); end
    vectors++; if (rx_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", rx_overflow); end
    for (int k = 0; k < 16; k++) begin
      vectors++; if (rx_data !== 32'h10 + k) begin miscompares++; $display("FAIL ovf_pop%0d: got %h want %h", k, rx_data, 32'h10 + k); end
      pulse_read();
    end
    pulse_read();  // pop on empty must be ignored
    vectors++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty: got c=%0d v=%b want 0/0", rx_count, rx_valid); end
    pulse_ov_clear();
    pulse_ur_clear();
    vectors++; if (rx_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
  endtask

  task automatic test_abort();
    set_mode(1'b0, 1'b0, 6'd8);
    tx_write(32'h5A);
    cs_low();
    spi_frame(32'h15, 5, got);
    cs_high();
    vectors++; if (rx_count !== 5'd0) begin miscompares++; $display("FAIL abort_nopush: got %0d want 0", rx_count); end
    vectors++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b oe=%b miso=%b want 0/0/0", busy, miso_oe, miso); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL abort_consumed: got %b want 1", tx_ready); end
    tx_write(32'h81);
    cs_low();
    spi_frame(32'h66, 8, got);
    vectors++; if (got !== 32'h81) begin miscompares++; $display("FAIL abort_next_miso: got %h want 00000081", got); end
    cs_high();
    vectors++; if (rx_data !== 32'h66 || rx_count !== 5'd1) begin miscompares++; $display("FAIL abort_next_rx: got %h c=%0d want 00000066/1", rx_data, rx_count); end
    pulse_read();
    pulse_ur_clear();
    enable = 1'b0;
    cs_low();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL disabled_start: got %b want 0", busy); end
    cs_high();
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    set_mode(1'b0, 1'b0, 6'd8);
    cs_low();  // no word loaded: underrun flag goes high
    spi_frame(32'h07, 3, got);
    vectors++; if (busy !== 1'b1 || tx_underrun !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got busy=%b ur=%b want 1/1", busy, tx_underrun); end
    #3 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin miscompares++; $display("FAIL ar_state: got busy=%b oe=%b miso=%b want 0/0/0", busy, miso_oe, miso); end
    vectors++; if (tx_underrun !== 1'b0 || tx_ready !== 1'b1 || rx_count !== 5'd0) begin miscompares++; $display("FAIL ar_flags: got ur=%b rdy=%b c=%0d want 0/1/0", tx_underrun, tx_ready, rx_count); end
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tx_write(32'h3C);
    cs_low();
    spi_frame(32'h99, 8, got);
    vectors++; if (got !== 32'h3C) begin miscompares++; $display("FAIL ar_fresh_miso: got %h want 0000003c", got); end
    cs_high();
    vectors++; if (rx_data !== 32'h99 || rx_count !== 5'd1) begin miscompares++; $display("FAIL ar_fresh_rx: got %h c=%0d want 00000099/1", rx_data, rx_count); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; frame_bits = 6'd8;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
    rx_read = 1'b0; ov_clear = 1'b0; ur_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
